// File: rtl/priority_encoder.sv
// Highest-index-wins priority encoder with an active-low enable.
// The index, valid flag and one-hot form are all registered.
// result is forced to 0 whenever result_valid is 0.
module priority_encoder #(
  parameter int WIDTH    = 16,
  parameter int RESULT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    data,
  input  logic                enable_n,
  output logic [RESULT_W-1:0] result,
  output logic                result_valid,
  output logic [WIDTH-1:0]    onehot
);

  logic                valid_nx;
  logic [RESULT_W-1:0] idx_nx;
  logic [WIDTH-1:0]    onehot_nx;
  logic [WIDTH-1:0]    window;
  logic [WIDTH-1:0]    half_mask;
  logic                upper_any;

  // Binary search from the top: each level decides one index bit.
  // At every level the live window is split in half. If the upper half
  // has any set bit, the index bit is set and the upper half becomes the
  // new window. Otherwise the lower half becomes the new window.
  always_comb begin
    window    = data;
    idx_nx    = '0;
    half_mask = '0;
    upper_any = 1'b0;
    for (int lvl = RESULT_W - 1; lvl >= 0; lvl--) begin
      half_mask = (WIDTH'(1) << (1 << lvl)) - WIDTH'(1);
      upper_any = |((window >> (1 << lvl)) & half_mask);
      idx_nx[lvl] = upper_any;
      if (upper_any) begin
        window = (window >> (1 << lvl)) & half_mask;
      end else begin
        window = window & half_mask;
      end
    end
    valid_nx  = ~enable_n & (|data);
    if (!valid_nx) begin
      idx_nx = '0;
    end
    onehot_nx = valid_nx ? (WIDTH'(1) << idx_nx) : '0;
  end

  // Capture the next-state values each cycle; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
      onehot       <= '0;
    end else begin
      result       <= idx_nx;
      result_valid <= valid_nx;
      onehot       <= onehot_nx;
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Directed bench for priority_encoder in its 16-bit and 8-bit forms.
// Both instances share clock, reset and enable; the 8-bit one sees data[7:0].
module tb_priority_encoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic        enable_n;

  logic [3:0]  result16;
  logic        valid16;
  logic [15:0] onehot16;
  logic [2:0]  result8;
  logic        valid8;
  logic [7:0]  onehot8;

  int total;
  int bad;

  priority_encoder #(.WIDTH(16)) dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data),
    .enable_n     (enable_n),
    .result       (result16),
    .result_valid (valid16),
    .onehot       (onehot16)
  );

  priority_encoder #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data[7:0]),
    .enable_n     (enable_n),
    .result       (result8),
    .result_valid (valid8),
    .onehot       (onehot8)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compares both instances against hand-computed index/valid values;
  // the expected one-hot is derived from those values.
  task automatic checkOutput(input string tag,
                             input logic [3:0] exp_r16, input logic exp_v16,
                             input logic [2:0] exp_r8, input logic exp_v8);
    logic [15:0] exp_oh16;
    logic [7:0]  exp_oh8;
    exp_oh16 = exp_v16 ? (16'd1 << exp_r16) : 16'd0;
    exp_oh8  = exp_v8  ? (8'd1 << exp_r8)   : 8'd0;
    checkValue({tag, " r16"},  32'(result16), 32'(exp_r16));
    checkValue({tag, " v16"},  32'(valid16),  32'(exp_v16));
    checkValue({tag, " oh16"}, 32'(onehot16), 32'(exp_oh16));
    checkValue({tag, " r8"},   32'(result8),  32'(exp_r8));
    checkValue({tag, " v8"},   32'(valid8),   32'(exp_v8));
    checkValue({tag, " oh8"},  32'(onehot8),  32'(exp_oh8));
  endtask

  // Drives inputs on the falling edge, then samples 1 unit after the
  // following rising edge, so each check sees exactly one cycle of latency.
  task automatic applyStimulus(input logic [15:0] d, input logic en_n);
    @(negedge clk);
    data     = d;
    enable_n = en_n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    data     = 16'hFFFF;
    enable_n = 1'b0;

    // Reset holds outputs low even with clocks and a full request vector.
    #2;
    checkOutput("reset_async", 4'd0, 1'b0, 3'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", 4'd0, 1'b0, 3'd0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", 4'd15, 1'b1, 3'd7, 1'b1);

    // Disabled: nothing is valid regardless of data.
    applyStimulus(16'h00C0, 1'b1);
    checkOutput("dis_00C0", 4'd0, 1'b0, 3'd0, 1'b0);
    applyStimulus(16'h0031, 1'b1);
    checkOutput("dis_0031", 4'd0, 1'b0, 3'd0, 1'b0);

    // Enabled, lower byte patterns.
    applyStimulus(16'h0000, 1'b0);
    checkOutput("en_0000", 4'd0, 1'b0, 3'd0, 1'b0);
    applyStimulus(16'h0020, 1'b0);
    checkOutput("en_0020", 4'd5, 1'b1, 3'd5, 1'b1);
    applyStimulus(16'h00EF, 1'b0);
    checkOutput("en_00EF", 4'd7, 1'b1, 3'd7, 1'b1);
    applyStimulus(16'h0080, 1'b0);
    checkOutput("en_0080", 4'd7, 1'b1, 3'd7, 1'b1);
    applyStimulus(16'h00F0, 1'b0);
    checkOutput("en_00F0", 4'd7, 1'b1, 3'd7, 1'b1);
    applyStimulus(16'h0003, 1'b0);
    checkOutput("en_0003", 4'd1, 1'b1, 3'd1, 1'b1);

    // Enable pulse 0 -> 1 -> 0 with fixed data.
    applyStimulus(16'h00EF, 1'b0);
    checkOutput("pulse_0", 4'd7, 1'b1, 3'd7, 1'b1);
    applyStimulus(16'h00EF, 1'b1);
    checkOutput("pulse_1", 4'd0, 1'b0, 3'd0, 1'b0);
    applyStimulus(16'h00EF, 1'b0);
    checkOutput("pulse_2", 4'd7, 1'b1, 3'd7, 1'b1);

    // Upper byte and extremes.
    applyStimulus(16'h8001, 1'b0);
    checkOutput("up_8001", 4'd15, 1'b1, 3'd0, 1'b1);
    applyStimulus(16'h0100, 1'b0);
    checkOutput("up_0100", 4'd8, 1'b1, 3'd0, 1'b0);
    applyStimulus(16'h0001, 1'b0);
    checkOutput("up_0001", 4'd0, 1'b1, 3'd0, 1'b1);
    applyStimulus(16'h4000, 1'b0);
    checkOutput("up_4000", 4'd14, 1'b1, 3'd0, 1'b0);
    applyStimulus(16'h7FFF, 1'b0);
    checkOutput("up_7FFF", 4'd14, 1'b1, 3'd7, 1'b1);
    applyStimulus(16'h1234, 1'b0);
    checkOutput("up_1234", 4'd12, 1'b1, 3'd5, 1'b1);

    // Mid-stream reset clears outputs immediately, without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset", 4'd0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    data     = 16'h0400;
    enable_n = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_reset", 4'd10, 1'b1, 3'd0, 1'b0);

    // Outputs hold between edges.
    @(negedge clk);
    data = 16'h0002;
    #1;
    checkOutput("hold_midcycle", 4'd10, 1'b1, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("after_hold", 4'd1, 1'b1, 3'd1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
